// File: rtl/dec_sel_counter_pkg.sv
// Shared types and defaults for the selectable-lane down counter.
package dec_sel_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH       = 4;
  localparam int unsigned DEF_OUT_W       = 2;
  localparam int unsigned DEF_AUTO_RELOAD = 0;

endpackage

// File: rtl/dec_sel_lane.sv
// Decrement, borrow and lane select for the down counter.
module dec_sel_lane
  import dec_sel_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned OUT_W = DEF_OUT_W
) (
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             sel_i,
  output logic [WIDTH:0]   z_o,
  output logic [OUT_W-1:0] lane_o
);

  logic [WIDTH-1:0] dec;
  logic             brw;

  assign dec = cnt_i - WIDTH'(1);
  assign brw = (cnt_i == '0);
  assign z_o = {~brw, dec};

  // low lane passes through, high lane is inverted
  assign lane_o = sel_i ? z_o[OUT_W-1:0]
                        : ~z_o[2*OUT_W-1:OUT_W];

endmodule

// File: rtl/dec_sel_counter.sv
// Loadable down counter with done pulse, optional auto-reload and lane output.
module dec_sel_counter
  import dec_sel_counter_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned OUT_W       = DEF_OUT_W,
  parameter int unsigned AUTO_RELOAD = DEF_AUTO_RELOAD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_val,
  output logic             ld_ready,
  input  logic             en,
  input  logic             sel,
  output logic [WIDTH-1:0] count,
  output logic [OUT_W-1:0] out,
  output logic             zero,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [OUT_W-1:0] out_q;
  logic             zero_q;
  logic             done_q, done_d;
  logic             ready_q;

  logic [WIDTH:0]   lane_z;
  logic [OUT_W-1:0] lane_out;
  logic [WIDTH-1:0] dec;
  logic             brw;
  logic             load;
  logic             ld_zero;

  dec_sel_lane #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W)
  ) u_lane (
    .cnt_i  (count_q),
    .sel_i  (sel),
    .z_o    (lane_z),
    .lane_o (lane_out)
  );

  assign dec     = lane_z[WIDTH-1:0];
  assign brw     = ~lane_z[WIDTH];
  assign load    = ld_valid & ready_q;
  assign ld_zero = (ld_val == '0);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (load) begin
      count_d  = ld_val;
      reload_d = ld_val;
      done_d   = ld_zero;
      state_d  = ld_zero ? ST_IDLE : ST_RUN;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          // a zero count leaves RUN; it is never decremented
          if (brw) begin
            state_d = (AUTO_RELOAD != 0) ? ST_HOLD
                                         : ST_IDLE;
          end else if (en) begin
            count_d = dec;
            done_d  = (count_q == WIDTH'(1));
          end
        end
        ST_HOLD: begin
          count_d = reload_q;
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      out_q    <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      out_q    <= lane_out;
      zero_q   <= (count_d == '0);
      done_q   <= done_d;
      ready_q  <= (state_d != ST_RUN);
    end
  end

  assign ld_ready = ready_q;
  assign count    = count_q;
  assign out      = out_q;
  assign zero     = zero_q;
  assign done     = done_q;

endmodule

// File: doc/dec_sel_counter.md
DEC_SEL_COUNTER -- requirements
Module: dec_sel_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter/decrement width; legal range 3..32.
REQ-002 Parameter OUT_W, default 2: selected output lane width; 2*OUT_W <= WIDTH+1.
REQ-003 Parameter AUTO_RELOAD, default 0: 1 = reload last loaded value on reaching zero; 0 = stop.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 ld_valid  input  1  load request.
REQ-007 ld_val  input  WIDTH  value to load.
REQ-008 ld_ready  output  1  block accepts a load this cycle.
REQ-009 en  input  1  decrement enable.
REQ-010 sel  input  1  output lane select.
REQ-011 count  output  WIDTH  current counter value, registered.
REQ-012 out  output  OUT_W  selected lane, registered.
REQ-013 zero  output  1  count == 0, registered.
REQ-014 done  output  1  single-cycle pulse on reaching zero.

Function
REQ-015 dec = count - 1 modulo 2^WIDTH; brw = 1 when count == 0 (borrow out).
REQ-016 Lane vector z[WIDTH:0] = {~brw, dec}.
REQ-017 sel=1: out next = z[OUT_W-1:0]; sel=0: out next = ~z[2*OUT_W-1:OUT_W].
REQ-018 out updates every cycle from the current registered count and sel; latency one cycle.
REQ-019 FSM states IDLE, RUN, HOLD.
REQ-020 IDLE: ld_ready=1; load (ld_valid&ld_ready) -> count=ld_val, reload register=ld_val, go RUN; ld_val==0 -> go IDLE and pulse done next cycle.
REQ-021 RUN: ld_ready=0; en=1 -> count=dec; en=0 -> count holds.
REQ-022 RUN with en=1 and count==1: count becomes 0, done pulses for the cycle count first reads 0.
REQ-023 At zero with AUTO_RELOAD=0: go IDLE; count holds 0.
REQ-024 At zero with AUTO_RELOAD=1: go HOLD for one cycle, then count = reload register and go RUN; ld_ready=1 during HOLD, and a load in HOLD overrides the reload value.
REQ-025 Load in the same cycle as the final decrement is not possible (ld_ready=0 in RUN); no silent drop.
REQ-026 count never wraps below 0 in RUN; decrement past zero is suppressed.
REQ-027 zero and done derive from registered count; no combinational path from inputs to any output.

Reset
REQ-028 rst=1 at a clock edge: state=IDLE, count=0, reload register=0, out=0, zero=1, done=0, ld_ready=1 the following cycle.
REQ-029 rst overrides simultaneous load or en; reset mid-RUN abandons the count with no done pulse.

Structure
REQ-030 Shared package holds the FSM state enum and the default parameter constants.
REQ-031 One sub-module, dec_sel_lane: combinational dec, brw, z and lane select, parametrised by WIDTH and OUT_W; reused by the top level.

Verification
REQ-032 Reset then load 5, en=1 continuously, WIDTH=4: count 5,4,3,2,1,0; done pulses once with count=0; ld_ready returns 1.
REQ-033 count=4 (0100), sel=1 -> out=2'b11 (dec=0011); sel=0 -> out=2'b11 (~z[3:2]=~00).
REQ-034 count=0, sel=1 -> out=2'b11 (dec=1111); sel=0 -> out=2'b00; zero=1.
REQ-035 AUTO_RELOAD=1, load 3, en=1 -> 3,2,1,0,HOLD,3,2...; load 6 during HOLD -> next count 6.
REQ-036 Load 7, en toggled 1,0,1: count 7,6,6,5; assert rst at count 5 -> count=0, zero=1, no done.
REQ-037 Load ld_val=0: done pulse next cycle, state IDLE, ld_ready stays 1.
